iobus_uart: RTL and testbench

- Memory-mapped UART peripheral that answers the MCU's IOBUS (IOBUS_ADDR / IOBUS_OUT / IOBUS_WR out of the core, IOBUS_IN back into it).
- Provides a TX FIFO feeding an 8N1 serializer and an 8N1 deserializer with a single-entry RX holding register.
- Sits beside the core at the top level and drives IOBUS_IN when its address window is selected.

---
 rtl/iobus_uart.sv | 272 +++++++++++++++++++++++++++
 tb/tb_iobus_uart.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iobus_uart.sv
// iobus_uart: memory-mapped 8N1 UART on the MCU IOBUS, with a TX FIFO and a single-entry RX holding register.
// Optional build macro IOBUS_UART_LOOPBACK_EN adds BAUD_DIV[16] LOOPBACK (TX line feeds RX, UART_TXD held high).
module iobus_uart #(
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
  parameter int          TX_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        UART_TXD,
  input  logic        UART_RXD
);

  localparam int AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // Bus handshake: IOBUS_WR is a one-cycle strobe with no back-pressure; a write is taken on every CLK
  // edge where IOBUS_WR=1 and the window is selected. Reads have no strobe and are purely combinational.
  logic       sel;
  logic [1:0] off;
  logic       wr_txdata, wr_rxdata, wr_status, wr_baud;

  assign sel       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign off       = IOBUS_ADDR[3:2];
  assign wr_txdata = sel && IOBUS_WR && (off == 2'd0);
  assign wr_rxdata = sel && IOBUS_WR && (off == 2'd1);
  assign wr_status = sel && IOBUS_WR && (off == 2'd2);
  assign wr_baud   = sel && IOBUS_WR && (off == 2'd3);

  logic [15:0] baud_div;
  logic [31:0] baud_rd;

  always_ff @(posedge CLK) begin
    if (!RST_N)       baud_div <= DEFAULT_DIV;
    else if (wr_baud) baud_div <= (IOBUS_OUT[15:0] < 16'd4) ? 16'd4 : IOBUS_OUT[15:0];
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_empty, push_ok, tx_pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok    = wr_txdata && (!fifo_full || tx_pop);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (tx_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= IOBUS_OUT[7:0];
  end

  // ---------------- TX FSM ----------------
  uart_state_e tx_state, tx_next;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_line, tx_busy, tx_bit_end;

  // tx_div is re-latched at every bit boundary so a BAUD_DIV write never cuts a bit short.
  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);

  always_ff @(posedge CLK) begin
    if (!RST_N) tx_state <= S_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (!fifo_empty) tx_next = S_START;
      S_START: if (tx_bit_end) tx_next = S_DATA;
      S_DATA:  if (tx_bit_end && (tx_bit == 3'd7)) tx_next = S_STOP;
      S_STOP:  if (tx_bit_end) tx_next = fifo_empty ? S_IDLE : S_START;
      default: tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    tx_pop  = 1'b0;
    case (tx_state)
      S_IDLE:  tx_pop  = !fifo_empty;
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tx_shift[0];
      S_STOP:  tx_pop  = tx_bit_end && !fifo_empty;
      default: tx_line = 1'b1;
    endcase
    tx_busy = (tx_state != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tx_cnt   <= '0;
      tx_div   <= DEFAULT_DIV;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (tx_pop) begin
      tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_div   <= baud_div;
    end else if (tx_state != S_IDLE) begin
      if (tx_bit_end) begin
        tx_cnt <= '0;
        tx_div <= baud_div;
        if (tx_state == S_DATA) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  // ---------------- RX path ----------------
  logic rx_in, rx_sync1, rx_sync2, rx_prev;

`ifdef IOBUS_UART_LOOPBACK_EN
  logic loopback;

  always_ff @(posedge CLK) begin
    if (!RST_N)       loopback <= 1'b0;
    else if (wr_baud) loopback <= IOBUS_OUT[16];
  end

  assign rx_in    = loopback ? tx_line : UART_RXD;
  assign UART_TXD = loopback ? 1'b1 : tx_line;
  assign baud_rd  = {15'b0, loopback, baud_div};

  logic unused_bus_bits;
  assign unused_bus_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:17]};
`else
  assign rx_in    = UART_RXD;
  assign UART_TXD = tx_line;
  assign baud_rd  = {16'b0, baud_div};

  logic unused_bus_bits;
  assign unused_bus_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:16]};
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= rx_in;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  uart_state_e rx_state, rx_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_fall, rx_half_end, rx_bit_end;
  logic        rx_cnt_clr, rx_sample, rx_done_ok, rx_done_err;

  // >= keeps the counters from wrapping if BAUD_DIV shrinks mid-frame.
  assign rx_fall     = rx_prev && !rx_sync2;
  assign rx_half_end = (rx_cnt >= {1'b0, baud_div[15:1]} - 16'd1);
  assign rx_bit_end  = (rx_cnt >= baud_div - 16'd1);

  always_ff @(posedge CLK) begin
    if (!RST_N) rx_state <= S_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_half_end) rx_next = rx_sync2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_bit_end && (rx_bit == 3'd7)) rx_next = S_STOP;
      S_STOP:  if (rx_bit_end) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_clr  = 1'b0;
    rx_sample   = 1'b0;
    rx_done_ok  = 1'b0;
    rx_done_err = 1'b0;
    case (rx_state)
      S_IDLE:  rx_cnt_clr = 1'b1;
      S_START: rx_cnt_clr = rx_half_end;
      S_DATA: begin
        rx_cnt_clr = rx_bit_end;
        rx_sample  = rx_bit_end;
      end
      S_STOP: begin
        rx_cnt_clr  = rx_bit_end;
        rx_done_ok  = rx_bit_end && rx_sync2;
        rx_done_err = rx_bit_end && !rx_sync2;
      end
      default: rx_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_cnt <= rx_cnt_clr ? 16'd0 : rx_cnt + 16'd1;
      if (rx_state == S_IDLE) rx_bit <= '0;
      if (rx_sample) begin
        rx_shift <= {rx_sync2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // ---------------- Holding register and sticky flags (hardware set beats software clear) ----------------
  logic [7:0] rx_byte;
  logic       rx_valid, rx_ovr, rx_ferr, tx_ovf;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
      tx_ovf   <= 1'b0;
    end else begin
      if (rx_done_ok) rx_byte <= rx_shift;

      if (rx_done_ok)     rx_valid <= 1'b1;
      else if (wr_rxdata) rx_valid <= 1'b0;

      if (rx_done_ok && rx_valid)          rx_ovr <= 1'b1;
      else if (wr_status && IOBUS_OUT[4])  rx_ovr <= 1'b0;

      if (wr_txdata && !push_ok)           tx_ovf <= 1'b1;
      else if (wr_status && IOBUS_OUT[5])  tx_ovf <= 1'b0;

      if (rx_done_err)                     rx_ferr <= 1'b1;
      else if (wr_status && IOBUS_OUT[6])  rx_ferr <= 1'b0;
    end
  end

  always_comb begin
    IOBUS_IN = 32'h0;
    if (sel) begin
      case (off)
        2'd1:    IOBUS_IN = {23'b0, rx_valid, rx_byte};
        2'd2:    IOBUS_IN = {25'b0, rx_ferr, tx_ovf, rx_ovr, rx_valid, tx_busy, fifo_empty, fifo_full};
        2'd3:    IOBUS_IN = baud_rd;
        default: IOBUS_IN = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_iobus_uart.sv
// Directed bench for iobus_uart: bus driver tasks, a UART_TXD frame monitor fed by an expected-byte queue,
// and one task per scenario with inline comparisons.
module tb_iobus_uart;

  localparam logic [31:0] A_TX = 32'h1100_0100;
  localparam logic [31:0] A_RX = 32'h1100_0104;
  localparam logic [31:0] A_ST = 32'h1100_0108;
  localparam logic [31:0] A_BD = 32'h1100_010C;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] IOBUS_ADDR = 32'h0;
  logic [31:0] IOBUS_OUT = 32'h0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        UART_TXD;
  logic        UART_RXD = 1'b1;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic [7:0] exp_q[$];

  iobus_uart dut (
    .CLK(CLK), .RST_N(RST_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .UART_TXD(UART_TXD), .UART_RXD(UART_RXD)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge CLK);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    @(negedge CLK);
    IOBUS_WR   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge CLK);
    IOBUS_ADDR = addr;
    #1 data = IOBUS_IN;
  endtask

  // Drives one 8N1 frame at 4 cycles per bit; a low stop bit is released high afterwards.
  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      UART_RXD = f[i];
      repeat (3) @(negedge CLK);
    end
    if (!stop) begin
      @(negedge CLK);
      UART_RXD = 1'b1;
    end
  endtask

  // ---------------- TX frame monitor (div 4) ----------------
  initial begin
    logic [7:0] b;
    logic       stop_bit;
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (mon_en && UART_TXD === 1'b0) begin
        @(negedge CLK);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge CLK);
          b[k] = UART_TXD;
        end
        repeat (4) @(negedge CLK);
        stop_bit = UART_TXD;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_frame: unexpected frame data=%02h stop=%0b, no byte expected", b, stop_bit);
        end else begin
          e = exp_q.pop_front();
          if ({stop_bit, b} !== {1'b1, e}) begin
            errors++;
            $display("FAIL tx_frame: got data=%02h stop=%0b, expected data=%02h stop=1", b, stop_bit, e);
          end
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (UART_TXD !== 1'b1) begin
        errors++;
        $display("FAIL reset_txd: cycle %0d got %b, expected 1", i, UART_TXD);
      end
    end
    RST_N = 1'b1;
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL reset_status: got %h, expected 00000002", rd); end
    bus_read(A_BD, rd);
    checks++;
    if (rd !== 32'd434) begin errors++; $display("FAIL reset_baud: got %0d, expected 434", rd); end
    bus_read(A_RX, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_rxdata: got %h, expected 00000000", rd); end
    bus_read(32'h1100_0110, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL outside_window_hi: got %h, expected 00000000", rd); end
    bus_read(32'h1100_00FC, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL outside_window_lo: got %h, expected 00000000", rd); end
    checks++;
    if (UART_TXD !== 1'b1) begin errors++; $display("FAIL reset_txd_after: got %b, expected 1", UART_TXD); end
  endtask

  task automatic test_baud_reg();
    logic [31:0] rd;
    logic [31:0] exp_bd;
    bus_write(A_BD, 32'h1);
    bus_read(A_BD, rd);
    checks++;
    if (rd !== 32'd4) begin errors++; $display("FAIL baud_clamp: got %h, expected 00000004", rd); end
`ifdef IOBUS_UART_LOOPBACK_EN
    exp_bd = 32'h0001_0010;
`else
    exp_bd = 32'h0000_0010;
`endif
    bus_write(A_BD, 32'hFFFF_0010);
    bus_read(A_BD, rd);
    checks++;
    if (rd !== exp_bd) begin errors++; $display("FAIL baud_upper: got %h, expected %h", rd, exp_bd); end
    bus_write(A_BD, 32'd4);
    bus_read(A_BD, rd);
    checks++;
    if (rd !== 32'd4) begin errors++; $display("FAIL baud_set4: got %h, expected 00000004", rd); end
  endtask

  task automatic test_tx_single();
    logic [31:0] rd;
    int t0, t_idle;
    bit done;
    mon_en = 1'b1;
    exp_q.push_back(8'hA5);
    bus_write(A_TX, 32'hA5);
    t0 = cyc; t_idle = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      bus_read(A_ST, rd);
      if (!rd[2]) begin done = 1; t_idle = cyc; end
    end
    checks++;
    if (!done || (t_idle - t0 - 1) != 40) begin
      errors++;
      $display("FAIL tx_busy_len: got %0d busy cycles (done=%0b), expected 40", t_idle - t0 - 1, done);
    end
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL tx_single_status: got %h, expected 00000002", rd); end
  endtask

  // The lead byte moves straight into the shifter; the next 8 fill the FIFO and the 9th overflows.
  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [7:0]  b;
    int t0, t_idle;
    bit done;
    exp_q.push_back(8'h10);
    bus_write(A_TX, 32'h10);
    t0 = cyc;
    for (int i = 1; i <= 8; i++) begin
      b = 8'h10 + 8'(i);
      exp_q.push_back(b);
      bus_write(A_TX, {24'h0, b});
      if (i == 7) begin
        bus_read(A_ST, rd);
        checks++;
        if (rd[0] !== 1'b0) begin errors++; $display("FAIL burst_not_full7: got full=%b, expected 0", rd[0]); end
      end
    end
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h5) begin errors++; $display("FAIL burst_full8: got %h, expected 00000005", rd); end
    bus_write(A_TX, 32'hEE);
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h25) begin errors++; $display("FAIL burst_ovf: got %h, expected 00000025", rd); end
    done = 0; t_idle = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      bus_read(A_ST, rd);
      if (!rd[2]) begin done = 1; t_idle = cyc; end
    end
    checks++;
    if (!done || (t_idle - t0 - 1) != 360) begin
      errors++;
      $display("FAIL burst_contiguous: got %0d busy cycles (done=%0b), expected 360", t_idle - t0 - 1, done);
    end
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h22) begin errors++; $display("FAIL burst_status_idle: got %h, expected 00000022", rd); end
    bus_write(A_ST, 32'h20);
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL ovf_clear: got %h, expected 00000002", rd); end
  endtask

  task automatic test_rx_frames();
    logic [31:0] rd;
    rx_send(8'h3C, 1'b1);
    repeat (6) @(negedge CLK);
    bus_read(A_RX, rd);
    checks++;
    if (rd !== 32'h13C) begin errors++; $display("FAIL rx_first: got %h, expected 0000013c", rd); end
    rx_send(8'h7E, 1'b1);
    repeat (6) @(negedge CLK);
    bus_read(A_RX, rd);
    checks++;
    if (rd !== 32'h17E) begin errors++; $display("FAIL rx_second: got %h, expected 0000017e", rd); end
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h1A) begin errors++; $display("FAIL rx_ovr_status: got %h, expected 0000001a", rd); end
    bus_write(A_RX, 32'h0);
    bus_write(A_ST, 32'h10);
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL rx_clear: got %h, expected 00000002", rd); end
    rx_send(8'h81, 1'b1);
    rx_send(8'h42, 1'b1);
    repeat (6) @(negedge CLK);
    bus_read(A_RX, rd);
    checks++;
    if (rd !== 32'h142) begin errors++; $display("FAIL rx_back_to_back: got %h, expected 00000142", rd); end
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h1A) begin errors++; $display("FAIL rx_b2b_status: got %h, expected 0000001a", rd); end
    bus_write(A_RX, 32'h0);
    bus_write(A_ST, 32'h10);
  endtask

  task automatic test_rx_errors();
    logic [31:0] rd;
    rx_send(8'hC3, 1'b0);
    repeat (6) @(negedge CLK);
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h42) begin errors++; $display("FAIL rx_ferr_status: got %h, expected 00000042", rd); end
    bus_read(A_RX, rd);
    checks++;
    if (rd[8] !== 1'b0) begin errors++; $display("FAIL rx_ferr_valid: got rx_valid=%b, expected 0", rd[8]); end
    bus_write(A_ST, 32'h40);
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL ferr_clear: got %h, expected 00000002", rd); end
    @(negedge CLK);
    UART_RXD = 1'b0;
    @(negedge CLK);
    UART_RXD = 1'b1;
    repeat (60) @(negedge CLK);
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL rx_glitch_status: got %h, expected 00000002", rd); end
    bus_read(A_RX, rd);
    checks++;
    if (rd[8] !== 1'b0) begin errors++; $display("FAIL rx_glitch_valid: got rx_valid=%b, expected 0", rd[8]); end
  endtask

`ifdef IOBUS_UART_LOOPBACK_EN
  task automatic test_loopback();
    logic [31:0] rd;
    int highs_missed;
    bus_write(A_BD, 32'h0001_0004);
    bus_read(A_BD, rd);
    checks++;
    if (rd !== 32'h0001_0004) begin errors++; $display("FAIL loopback_reg: got %h, expected 00010004", rd); end
    bus_write(A_TX, 32'h55);
    highs_missed = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge CLK);
      if (UART_TXD !== 1'b1) highs_missed++;
    end
    checks++;
    if (highs_missed != 0) begin errors++; $display("FAIL loopback_txd: got %0d low cycles, expected 0", highs_missed); end
    bus_read(A_RX, rd);
    checks++;
    if (rd !== 32'h155) begin errors++; $display("FAIL loopback_rx: got %h, expected 00000155", rd); end
    bus_write(A_BD, 32'd4);
    bus_write(A_RX, 32'h0);
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    bit found;
    mon_en = 1'b0;
    bus_write(A_TX, 32'h00);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK);
      if (UART_TXD === 1'b0) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midreset_start: got no start bit within 10 cycles, expected one"); end
    repeat (8) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    checks++;
    if (UART_TXD !== 1'b1) begin errors++; $display("FAIL midreset_txd: got %b, expected 1", UART_TXD); end
    RST_N = 1'b1;
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL midreset_status: got %h, expected 00000002", rd); end
    bus_read(A_BD, rd);
    checks++;
    if (rd !== 32'd434) begin errors++; $display("FAIL midreset_baud: got %0d, expected 434", rd); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_baud_reg();
    test_tx_single();
    test_back_to_back();
    test_rx_frames();
    test_rx_errors();
`ifdef IOBUS_UART_LOOPBACK_EN
    test_loopback();
`endif
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL tx_frames_missing: got %0d bytes never seen on UART_TXD, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
